circuit: RTL and testbench

//  Four-slot parking-lot controller with occupancy tracking and a multiplexed
//  5-digit seven-segment status display. Entry/exit sensors and a 2-bit slot

---
 rtl/circuit.sv | 113 +++++++++++
 tb/tb_circuit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/circuit.sv
// Four-slot parking-lot controller: occupancy register, door/full lamps and an
// optional multiplexed 5-digit seven-segment status display (macro SEVEN_SEG_EN).
module circuit (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] switch,
    output logic [3:0] parking_slots,
    output logic       door_open_light,
    output logic       full_light,
    output logic [2:0] capacity,
    output logic [2:0] best_place,
    output logic [7:0] sev_data,
    output logic [4:0] sev_sel
);

    function automatic logic [2:0] occ_count(input logic [3:0] s);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) c = c + {2'b00, s[i]};
        return c;
    endfunction

    // 1-based position of the lowest free slot, 0 when every slot is taken
    function automatic logic [2:0] lowest_free(input logic [3:0] s);
        logic [2:0] p;
        if (!s[0])      p = 3'd1;
        else if (!s[1]) p = 3'd2;
        else if (!s[2]) p = 3'd3;
        else if (!s[3]) p = 3'd4;
        else            p = 3'd0;
        return p;
    endfunction

    logic [3:0] slots_q, slots_d;
    logic       door_q, door_d;
    logic       entry_ok, exit_ok;

    always_comb begin
        entry_ok = entry_sensor && (slots_q != 4'hF);
        exit_ok  = exit_sensor && slots_q[switch];
        slots_d  = slots_q;
        if (exit_ok)
            slots_d[switch] = 1'b0;
        // Entry targets a slot free before the edge, so it never collides with the exit bit
        if (entry_ok)
            slots_d[lowest_free(slots_q) - 3'd1] = 1'b1;
        door_d = entry_ok || exit_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= 4'h0;
            door_q  <= 1'b0;
        end else begin
            slots_q <= slots_d;
            door_q  <= door_d;
        end
    end

    assign parking_slots   = slots_q;
    assign door_open_light = door_q;
    assign capacity        = 3'd4 - occ_count(slots_q);
    assign full_light      = (slots_q == 4'hF);
    assign best_place      = lowest_free(slots_q);

`ifdef SEVEN_SEG_EN
    function automatic logic [7:0] seg_hex(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'h3F;  4'h1: g = 8'h06;  4'h2: g = 8'h5B;  4'h3: g = 8'h4F;
            4'h4: g = 8'h66;  4'h5: g = 8'h6D;  4'h6: g = 8'h7D;  4'h7: g = 8'h07;
            4'h8: g = 8'h7F;  4'h9: g = 8'h6F;  4'hA: g = 8'h77;  4'hB: g = 8'h7C;
            4'hC: g = 8'h39;  4'hD: g = 8'h5E;  4'hE: g = 8'h79;  default: g = 8'h71;
        endcase
        return g;
    endfunction

    logic [2:0] scan_q, scan_d;
    logic [7:0] sev_data_q, sev_data_d;

    // Segment data is built from the post-edge state so it always matches the lit digit
    always_comb begin
        scan_d = (scan_q == 3'd4) ? 3'd0 : scan_q + 3'd1;
        case (scan_d)
            3'd0:    sev_data_d = seg_hex({1'b0, 3'd4 - occ_count(slots_d)});
            3'd1:    sev_data_d = seg_hex({1'b0, lowest_free(slots_d)});
            3'd2:    sev_data_d = (slots_d == 4'hF) ? 8'h71 : 8'h00;
            3'd3:    sev_data_d = door_d ? 8'h5C : 8'h00;
            3'd4:    sev_data_d = seg_hex({1'b0, occ_count(slots_d)});
            default: sev_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q     <= 3'd0;
            sev_data_q <= seg_hex(4'd4);
        end else begin
            scan_q     <= scan_d;
            sev_data_q <= sev_data_d;
        end
    end

    assign sev_sel  = 5'b00001 << scan_q;
    assign sev_data = sev_data_q;
`else
    assign sev_sel  = 5'b00000;
    assign sev_data = 8'h00;
`endif

endmodule

// File: tb/tb_circuit.sv
// Randomized bench for the parking controller: occupancy model plus display
// model feed an expected queue checked every cycle, with directed scenarios first.
module tb_circuit;
    localparam int W = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [1:0] switch = 2'd0;
    logic [3:0] parking_slots;
    logic       door_open_light;
    logic       full_light;
    logic [2:0] capacity;
    logic [2:0] best_place;
    logic [7:0] sev_data;
    logic [4:0] sev_sel;

    circuit dut (
        .clk(clk), .rst(rst), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .switch(switch), .parking_slots(parking_slots), .door_open_light(door_open_light),
        .full_light(full_light), .capacity(capacity), .best_place(best_place),
        .sev_data(sev_data), .sev_sel(sev_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural state: which slots hold a car, door lamp, lit digit
    bit occ[4];
    bit m_door;
    int m_scan;
    bit m_valid = 1'b0;
    logic [7:0] glyph[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cars();
        int n = 0;
        for (int i = 0; i < 4; i++) n += occ[i];
        return n;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < 4; i++) if (!occ[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [W-1:0] expected();
        logic [3:0] s;
        logic [4:0] sel;
        logic [7:0] dat;
        int free;
        for (int i = 0; i < 4; i++) s[i] = occ[i];
        free = 4 - cars();
        sel = 5'd0;
        dat = 8'd0;
`ifdef SEVEN_SEG_EN
        sel = 5'd0;
        sel[m_scan] = 1'b1;
        case (m_scan)
            0: dat = glyph[free];
            1: dat = glyph[first_free()];
            2: dat = (free == 0) ? 8'h71 : 8'h00;
            3: dat = m_door ? 8'h5C : 8'h00;
            default: dat = glyph[cars()];
        endcase
`endif
        return {s, m_door, (free == 0), 3'(free), 3'(first_free()), sel, dat};
    endfunction

    // Reference model update at each active edge
    always @(posedge clk) begin
        bit e_ok, x_ok;
        int slot;
        if (rst) begin
            for (int i = 0; i < 4; i++) occ[i] = 1'b0;
            m_door = 1'b0;
            m_scan = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            e_ok = entry_sensor && (cars() < 4);
            x_ok = exit_sensor && occ[switch];
            slot = first_free();
            if (x_ok) occ[switch] = 1'b0;
            if (e_ok) occ[slot - 1] = 1'b1;
            m_door = e_ok || x_ok;
            m_scan = (m_scan + 1) % 5;
        end
        if (m_valid) exp_q.push_back(expected());
    end

    // Compare process on the opposite edge
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slots", 32'(parking_slots), 32'(e[24:21]));
            check("door", 32'(door_open_light), 32'(e[20]));
            check("full", 32'(full_light), 32'(e[19]));
            check("capacity", 32'(capacity), 32'(e[18:16]));
            check("best_place", 32'(best_place), 32'(e[15:13]));
            check("sev_sel", 32'(sev_sel), 32'(e[12:8]));
            check("sev_data", 32'(sev_data), 32'(e[7:0]));
        end
    end

    task automatic drive(input bit e, input bit x, input logic [1:0] s, input bit r);
        entry_sensor = e;
        exit_sensor = x;
        switch = s;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string tag, input logic [3:0] s, input bit door,
                       input logic [2:0] cap, input logic [2:0] best, input bit full);
        check({tag, "_slots"}, 32'(parking_slots), 32'(s));
        check({tag, "_door"}, 32'(door_open_light), 32'(door));
        check({tag, "_cap"}, 32'(capacity), 32'(cap));
        check({tag, "_best"}, 32'(best_place), 32'(best));
        check({tag, "_full"}, 32'(full_light), 32'(full));
    endtask

    logic [3:0] fill_seq[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [2:0] fill_cap[4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [2:0] fill_best[4] = '{3'd2, 3'd3, 3'd4, 3'd0};

    initial begin
        drive(0, 0, 2'd0, 1);
        rst = 1'b0;
        pin("reset", 4'b0000, 0, 3'd4, 3'd1, 0);
`ifdef SEVEN_SEG_EN
        check("reset_sev_sel", 32'(sev_sel), 32'h01);
        check("reset_sev_data", 32'(sev_data), 32'h66);
`else
        check("off_sev_sel", 32'(sev_sel), 32'h00);
        check("off_sev_data", 32'(sev_data), 32'h00);
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 2'd0, 0);
            pin("fill", fill_seq[i], 1, fill_cap[i], fill_best[i], (i == 3));
        end
        drive(1, 0, 2'd0, 0);
        pin("refused", 4'b1111, 0, 3'd0, 3'd0, 1);
        drive(0, 1, 2'd2, 0);
        pin("exit2", 4'b1011, 1, 3'd1, 3'd3, 0);
        drive(1, 0, 2'd0, 0);
        pin("refill", 4'b1111, 1, 3'd0, 3'd0, 1);
        drive(0, 1, 2'd1, 0);
        drive(0, 1, 2'd3, 0);
        pin("to0101", 4'b0101, 1, 3'd2, 3'd2, 0);
        drive(1, 1, 2'd0, 0);
        pin("both", 4'b0110, 1, 3'd2, 3'd1, 0);
        drive(0, 1, 2'd3, 0);
        pin("exit_empty", 4'b0110, 0, 3'd2, 3'd1, 0);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                  2'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
        end
        drive(0, 0, 2'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
